// File: rtl/div_pkg.sv
// Shared types for the divider-sharing arbiter: FSM states, default widths
// and the registered response record.
package div_pkg;

    localparam int DIV_W    = 10;
    localparam int DIV_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIV_ID_W-1:0] id;
        logic [DIV_W-1:0]    q;
        logic                dvz;
        logic                ovf;
        logic                tmo;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request strictly after ptr_i,
// wrapping through index 0, returned as a one-hot vector plus its index.
module rr_arbiter
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned         c;
        logic [NUM_REQ-1:0]  shifted;
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        c       = 0;
        shifted = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            c       = (32'(ptr_i) + k) % NUM_REQ;
            shifted = req_i >> c;
            if (!any_o && shifted[0]) begin
                any_o = 1'b1;
                gnt_o = NUM_REQ'(1) << c;
                idx_o = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// Shares one restoring divider between NUM_REQ requesters with round-robin
// arbitration. Optional watchdog abort is enabled by defining DIV_TMO_EN.
module div_share_arb
    import div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = DIV_W,
    parameter int ID_W    = 3,
    parameter int TMO_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [W-1:0]         resp_q,
    output logic                 resp_dvz,
    output logic                 resp_ovf,
    output logic                 resp_tmo,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    output logic                 div_start,
    output logic                 div_sclr,
    input  logic [W-1:0]         div_q,
    input  logic                 div_dvz,
    input  logic                 div_ovf,
    input  logic                 div_busy,
    input  logic                 div_valid
);

    state_t             state_q;
    logic [ID_W-1:0]    rr_q;
    logic [ID_W-1:0]    id_q;
    logic [W-1:0]       a_q, b_q;
    logic [W-1:0]       a_d, b_d;
    logic               start_q;
    logic               rvalid_q;
    logic               sclr_q;
    resp_t              rsp_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               cmpl;
    logic               unused_ok;

`ifdef DIV_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC) + 1;
    logic [CNT_W-1:0] cnt_q;
`else
    localparam int unused_tmo = TMO_CYC;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign a_d       = W'(req_a >> (32'(gnt_idx) * W));
    assign b_d       = W'(req_b >> (32'(gnt_idx) * W));
    assign cmpl      = div_valid | div_dvz | div_ovf;
    // Busy carries no information the completion strobes do not already give.
    assign unused_ok = div_busy;

    // Accept is combinational so the requester sees it in the grant cycle itself.
    assign req_ready  = (state_q == IDLE && rst_n) ? gnt : '0;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign div_start  = start_q;
    assign div_sclr   = sclr_q;
    assign resp_valid = rvalid_q;
    assign resp_id    = ID_W'(rsp_q.id);
    assign resp_q     = W'(rsp_q.q);
    assign resp_dvz   = rsp_q.dvz;
    assign resp_ovf   = rsp_q.ovf;
    assign resp_tmo   = rsp_q.tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            sclr_q   <= 1'b0;
            rsp_q    <= '0;
`ifdef DIV_TMO_EN
            cnt_q    <= '0;
`endif
        end else begin
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            sclr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        id_q    <= gnt_idx;
                        rr_q    <= gnt_idx;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef DIV_TMO_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cmpl) begin
                        rsp_q    <= '{id: DIV_ID_W'(id_q), q: DIV_W'(div_q),
                                      dvz: div_dvz, ovf: div_ovf, tmo: 1'b0};
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end
`ifdef DIV_TMO_EN
                    else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                        rsp_q    <= '{id: DIV_ID_W'(id_q), q: '0,
                                      dvz: 1'b0, ovf: 1'b0, tmo: 1'b1};
                        sclr_q   <= 1'b1;
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
Shares one 10-bit restoring divider (controller + datapath pair) between NUM_REQ requesters.
- Round-robin arbitration; latches the winner's operands and pulses the divider start.
- Waits for completion, then returns quotient and status tagged with the requester id.
- Sits between requester blocks and the divider top; it is the only driver of the divider start and sclr.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
W, 10, operand/quotient width (matches divider)
ID_W, 3, width of response id (>= clog2(NUM_REQ))
TMO_CYC, 64, watchdog limit in cycles (used only with DIV_TMO_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_a  in  NUM_REQ*W  dividends, requester i at [i*W +: W]
req_b  in  NUM_REQ*W  divisors, same packing
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  1  one-cycle result pulse
resp_id  out  ID_W  requester index of the result
resp_q  out  W  quotient
resp_dvz  out  1  divide-by-zero flag
resp_ovf  out  1  overflow flag
resp_tmo  out  1  watchdog abort flag (0 when DIV_TMO_EN is undefined)
div_a  out  W  divider dividend
div_b  out  W  divider divisor
div_start  out  1  divider start pulse
div_sclr  out  1  divider synchronous clear
div_q  in  W  divider quotient
div_dvz  in  1  divider dvz
div_ovf  in  1  divider ovf
div_busy  in  1  divider busy
div_valid  in  1  divider result valid

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; rr pointer=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0, including latched operands and resp fields.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr+1 with wrap (round-robin).
  - In the same cycle: req_ready[g]=1, latch req_a/req_b of g into the operand regs, latch g into the id reg, set rr=g, go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- Accept handshake: the requester sees req_ready[g]=1 and may drop or change req_valid and operands from the next cycle.
- ISSUE:
  - div_start=1 for exactly one cycle; div_a/div_b are driven from the latched regs.
  - Go to WAIT.
- WAIT:
  - div_a/div_b stay stable.
  - Completion = div_valid | div_dvz | div_ovf, sampled on the clock edge.
  - On completion, capture div_q, div_dvz and div_ovf into the resp regs, then go to DONE.
  - A completion seen in the first WAIT cycle is accepted (zero-latency divider tolerated).
- DONE:
  - resp_valid=1 for one cycle; resp_id/q/dvz/ovf hold their values until the next DONE.
  - Go to IDLE. The next grant occurs no earlier than the IDLE cycle.
- Throughput and latency: minimum 4 cycles per operation plus divider latency. Request-to-accept latency is at most one operation per other requester ahead in round-robin order.
- Boundary conditions:
  - req_valid dropped before grant: no effect.
  - Simultaneous requests: strict rotation, no starvation.
  - Winner at rr wrap-around: searches index 0 next.
- div_sclr=0 except on a watchdog abort.
- rst_n low mid-operation: immediate return to reset values, no resp_valid. The divider is expected to be cleared by the system reset independently.

Optional Feature:
DIV_TMO_EN
- Defined:
  - A cycle counter clears on ISSUE and increments in WAIT.
  - When it reaches TMO_CYC-1 without a completion: div_sclr=1 for one cycle, resp_q=0, resp_dvz=0, resp_ovf=0, resp_tmo=1, go to DONE.
  - Completion and timeout in the same cycle: completion wins.
- Undefined: no counter exists, resp_tmo is tied to 0, and div_sclr is tied to 0.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - the W default;
  - the response struct {id, q, dvz, ovf, tmo}.
- One sub-module, rr_arbiter: combinational round-robin grant from req_valid and the rr pointer, producing a one-hot grant plus an index.

Test Plan:
- Single request, req0 a=100 b=7: req_ready=01, then div_start pulses one cycle later; on div_valid, resp_valid=1 with id=0, q=14, dvz=0, ovf=0.
- Both requesters held valid with req0 a=50 b=5 and req1 a=9 b=3: grants alternate 0,1,0,1; responses are id0 q=10 and id1 q=3, in grant order.
- Division by zero, req1 a=33 b=0: divider asserts dvz; response id=1, dvz=1; FSM returns to IDLE and the next request is served normally.
- Assert rst_n=0 during WAIT: all outputs become 0 immediately, no resp_valid; after release, req0 has first priority.
- With DIV_TMO_EN and TMO_CYC=8, the divider never completes: div_sclr pulses exactly once, resp_tmo=1 and resp_q=0 on resp_valid.
- Divider completes in the first WAIT cycle (div_valid=1): result is captured, resp_valid arrives one cycle later, and there is no double start.
